// File: rtl/bus_arbiter_pkg.sv
// Shared bus types for the core-side ibus/dbus ports and the single-beat memory port.
package common;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
    } mbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } mbus_resp_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of core-side request/response and memory-side request/response signals.
interface bus_arbiter_if;
    import common::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    mbus_req_t  mreq;
    mbus_resp_t mresp;

    modport master (output ireq, dreq, mresp, input iresp, dresp, mreq);
    modport slave  (input ireq, dreq, mresp, output iresp, dresp, mreq);
endinterface

// File: rtl/bus_arbiter.sv
// Arbitrates core instruction and data requests onto one single-beat memory port,
// favouring dbus but forcing an ibus grant after STARVE_MAX consecutive dbus wins.
module bus_arbiter
    import common::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {IDLE, IBUS, DBUS, IDONE, DDONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   starve_cnt_reg, starve_cnt_next;
    mbus_req_t       req_reg, req_next;
    logic [63:0]     data_reg, data_next;
    logic            starve_full;
    logic            forced_ibus;
    logic            beat_done;

    assign starve_full = (starve_cnt_reg == CW'(STARVE_MAX));
    assign forced_ibus = starve_full && bus.ireq.valid;
    assign beat_done   = bus.mresp.ready && bus.mresp.last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
            req_reg        <= '0;
            data_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            req_reg        <= req_next;
            data_reg       <= data_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        req_next        = req_reg;
        data_next       = data_reg;
        bus.mreq        = req_reg;
        bus.mreq.valid  = 1'b0;
        bus.iresp       = '0;
        bus.dresp       = '0;

        case (state_reg)
            IDLE: begin
                if (bus.dreq.valid && !forced_ibus) begin
                    state_next = DBUS;
                    req_next   = '{valid:    1'b1,
                                   is_write: |bus.dreq.strobe,
                                   size:     bus.dreq.size,
                                   addr:     bus.dreq.addr,
                                   strobe:   bus.dreq.strobe,
                                   data:     bus.dreq.data};
                    // Only dbus wins taken while ibus waits count toward starvation.
                    if (!bus.ireq.valid)
                        starve_cnt_next = '0;
                    else if (!starve_full)
                        starve_cnt_next = starve_cnt_reg + 1'b1;
                end else if (bus.ireq.valid) begin
                    state_next      = IBUS;
                    starve_cnt_next = '0;
                    req_next        = '{valid:    1'b1,
                                        is_write: 1'b0,
                                        size:     MSIZE4,
                                        addr:     bus.ireq.addr,
                                        strobe:   8'h00,
                                        data:     64'h0};
                end else begin
                    starve_cnt_next = '0;
                end
            end
            IBUS: begin
                bus.mreq.valid = 1'b1;
                if (beat_done) begin
                    state_next = IDONE;
                    data_next  = bus.mresp.data;
                end
            end
            DBUS: begin
                bus.mreq.valid = 1'b1;
                if (beat_done) begin
                    state_next = DDONE;
                    data_next  = bus.mresp.data;
                end
            end
            IDONE: begin
                bus.iresp.addr_ok = 1'b1;
                bus.iresp.data_ok = 1'b1;
                // The 32-bit instruction word sits in whichever half addr[2] selects.
                bus.iresp.data    = req_reg.addr[2] ? data_reg[63:32] : data_reg[31:0];
                state_next        = IDLE;
            end
            DDONE: begin
                bus.dresp.addr_ok = 1'b1;
                bus.dresp.data_ok = 1'b1;
                bus.dresp.data    = data_reg;
                state_next        = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed vector table plus hand-written multi-cycle sequences for bus_arbiter.
module tb_bus_arbiter;
    import common::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    bus_arbiter_if bus ();

    bus_arbiter #(.STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        ival;
        logic [63:0] iaddr;
        logic        dval;
        logic [63:0] daddr;
        logic [7:0]  dstrb;
        logic [63:0] ddata;
        logic        mrdy;
        logic        mlast;
        logic [63:0] mdata;
        logic        e_mval;
        logic        e_mwr;
        logic [63:0] e_maddr;
        logic        e_iok;
        logic [31:0] e_idata;
        logic        e_dok;
        logic [63:0] e_ddata;
    } vec_t;

    vec_t vecs [0:10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.ireq.valid  = v.ival;
        bus.ireq.addr   = v.iaddr;
        bus.dreq.valid  = v.dval;
        bus.dreq.addr   = v.daddr;
        bus.dreq.strobe = v.dstrb;
        bus.dreq.data   = v.ddata;
        bus.mresp.ready = v.mrdy;
        bus.mresp.last  = v.mlast;
        bus.mresp.data  = v.mdata;
    endtask

    task automatic set_mresp(input logic rdy, input logic lst, input logic [63:0] d);
        bus.mresp.ready = rdy;
        bus.mresp.last  = lst;
        bus.mresp.data  = d;
    endtask

    initial begin
        logic [63:0] exp_addr;
        int pulses;

        bus.ireq  = '0;
        bus.dreq  = '0;
        bus.dreq.size = MSIZE8;
        bus.mresp = '0;

        //                ival iaddr               dval daddr               strb   ddata         rdy   lst   mdata                      mval  mwr   maddr               iok   idata         dok   ddata
        vecs[0]  = '{1'b1, 64'h8000_0004, 1'b0, 64'h0,         8'h00, 64'h0,    1'b0, 1'b0, 64'h0,                 1'b1, 1'b0, 64'h8000_0004, 1'b0, 32'h0,        1'b0, 64'h0};
        vecs[1]  = '{1'b0, 64'h0,         1'b0, 64'h0,         8'h00, 64'h0,    1'b1, 1'b0, 64'hBAD,               1'b1, 1'b0, 64'h8000_0004, 1'b0, 32'h0,        1'b0, 64'h0};
        vecs[2]  = '{1'b1, 64'h9000_0000, 1'b0, 64'h0,         8'h00, 64'h0,    1'b0, 1'b0, 64'h0,                 1'b1, 1'b0, 64'h8000_0004, 1'b0, 32'h0,        1'b0, 64'h0};
        vecs[3]  = '{1'b0, 64'h0,         1'b0, 64'h0,         8'h00, 64'h0,    1'b1, 1'b1, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 64'h0,        1'b1, 32'h1111_2222, 1'b0, 64'h0};
        vecs[4]  = '{1'b0, 64'h0,         1'b0, 64'h0,         8'h00, 64'h0,    1'b0, 1'b0, 64'h0,                 1'b0, 1'b0, 64'h0,         1'b0, 32'h0,        1'b0, 64'h0};
        vecs[5]  = '{1'b1, 64'h8000_0008, 1'b1, 64'h8000_1000, 8'hFF, 64'hDEAD, 1'b0, 1'b0, 64'h0,                 1'b1, 1'b1, 64'h8000_1000, 1'b0, 32'h0,        1'b0, 64'h0};
        vecs[6]  = '{1'b1, 64'h8000_0008, 1'b0, 64'h0,         8'h00, 64'h0,    1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 1'b0, 64'h0,        1'b0, 32'h0,        1'b1, 64'hAAAA_BBBB_CCCC_DDDD};
        vecs[7]  = '{1'b1, 64'h8000_0008, 1'b0, 64'h0,         8'h00, 64'h0,    1'b0, 1'b0, 64'h0,                 1'b0, 1'b0, 64'h0,         1'b0, 32'h0,        1'b0, 64'h0};
        vecs[8]  = '{1'b1, 64'h8000_0008, 1'b0, 64'h0,         8'h00, 64'h0,    1'b0, 1'b0, 64'h0,                 1'b1, 1'b0, 64'h8000_0008, 1'b0, 32'h0,        1'b0, 64'h0};
        vecs[9]  = '{1'b0, 64'h0,         1'b0, 64'h0,         8'h00, 64'h0,    1'b1, 1'b1, 64'h5555_6666_7777_8888, 1'b0, 1'b0, 64'h0,        1'b1, 32'h7777_8888, 1'b0, 64'h0};
        vecs[10] = '{1'b0, 64'h0,         1'b0, 64'h0,         8'h00, 64'h0,    1'b0, 1'b0, 64'h0,                 1'b0, 1'b0, 64'h0,         1'b0, 32'h0,        1'b0, 64'h0};

        // Reset state
        #2;
        check("reset_mreq", 64'(bus.mreq), 64'h0);
        check("reset_iresp", 64'(bus.iresp), 64'h0);
        check("reset_dresp_ok", {62'h0, bus.dresp.addr_ok, bus.dresp.data_ok}, 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        $display("reset released");

        // Table-driven vectors
        for (int i = 0; i <= 10; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d_mval", i), 64'(bus.mreq.valid), 64'(vecs[i].e_mval));
            check($sformatf("v%0d_iok", i), {62'h0, bus.iresp.addr_ok, bus.iresp.data_ok}, {62'h0, {2{vecs[i].e_iok}}});
            check($sformatf("v%0d_dok", i), {62'h0, bus.dresp.addr_ok, bus.dresp.data_ok}, {62'h0, {2{vecs[i].e_dok}}});
            if (vecs[i].e_mval) begin
                check($sformatf("v%0d_maddr", i), bus.mreq.addr, vecs[i].e_maddr);
                check($sformatf("v%0d_mwr", i), 64'(bus.mreq.is_write), 64'(vecs[i].e_mwr));
                check($sformatf("v%0d_msize", i), 64'(bus.mreq.size), vecs[i].e_mwr ? 64'(MSIZE8) : 64'(MSIZE4));
            end
            if (vecs[i].e_iok)
                check($sformatf("v%0d_idata", i), 64'(bus.iresp.data), 64'(vecs[i].e_idata));
            if (vecs[i].e_dok)
                check($sformatf("v%0d_ddata", i), bus.dresp.data, vecs[i].e_ddata);
            $display("vec %0d: mval=%b maddr=%h iok=%b dok=%b", i, bus.mreq.valid, bus.mreq.addr,
                     bus.iresp.data_ok, bus.dresp.data_ok);
        end

        // Starvation: both requesters held valid, the fifth grant must go to ibus
        bus.ireq.valid  = 1'b1;
        bus.ireq.addr   = 64'h8000_0100;
        bus.dreq.valid  = 1'b1;
        bus.dreq.addr   = 64'h8000_2000;
        bus.dreq.strobe = 8'h00;
        bus.dreq.size   = MSIZE8;
        for (int g = 0; g < 5; g++) begin
            exp_addr = (g < 4) ? 64'h8000_2000 : 64'h8000_0100;
            @(negedge clk);
            check($sformatf("starve%0d_mval", g), 64'(bus.mreq.valid), 64'h1);
            check($sformatf("starve%0d_maddr", g), bus.mreq.addr, exp_addr);
            check($sformatf("starve%0d_mwr", g), 64'(bus.mreq.is_write), 64'h0);
            set_mresp(1'b1, 1'b1, 64'(g));
            @(negedge clk);
            check($sformatf("starve%0d_iok", g), 64'(bus.iresp.data_ok), (g < 4) ? 64'h0 : 64'h1);
            check($sformatf("starve%0d_dok", g), 64'(bus.dresp.data_ok), (g < 4) ? 64'h1 : 64'h0);
            set_mresp(1'b0, 1'b0, 64'h0);
            @(negedge clk);
            $display("starve grant %0d: addr=%h", g, exp_addr);
        end
        bus.ireq.valid = 1'b0;
        bus.dreq.valid = 1'b0;
        @(negedge clk);
        check("starve_end_idle", 64'(bus.mreq.valid), 64'h0);

        // dreq.addr changes mid-transaction; latched 0x100 must persist
        bus.dreq.valid  = 1'b1;
        bus.dreq.addr   = 64'h100;
        bus.dreq.strobe = 8'h0F;
        bus.dreq.data   = 64'h1234;
        bus.dreq.size   = MSIZE4;
        @(negedge clk);
        check("chg_mval", 64'(bus.mreq.valid), 64'h1);
        check("chg_strobe", 64'(bus.mreq.strobe), 64'h0F);
        check("chg_mwr", 64'(bus.mreq.is_write), 64'h1);
        bus.dreq.addr = 64'h200;
        repeat (2) begin
            @(negedge clk);
            check("chg_maddr", bus.mreq.addr, 64'h100);
        end
        set_mresp(1'b1, 1'b1, 64'h42);
        bus.dreq.valid = 1'b0;
        @(negedge clk);
        check("chg_dok", 64'(bus.dresp.data_ok), 64'h1);
        check("chg_ddata", bus.dresp.data, 64'h42);
        set_mresp(1'b0, 1'b0, 64'h0);
        @(negedge clk);
        $display("addr-change transaction complete");

        // ireq.valid dropped during IBUS: exactly one iresp pulse
        bus.ireq.valid = 1'b1;
        bus.ireq.addr  = 64'h8000_0010;
        @(negedge clk);
        check("drop_mval", 64'(bus.mreq.valid), 64'h1);
        bus.ireq.valid = 1'b0;
        @(negedge clk);
        check("drop_hold", 64'(bus.mreq.valid), 64'h1);
        set_mresp(1'b1, 1'b1, 64'hCAFE_F00D_1234_5678);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("drop_idata", 64'(bus.iresp.data), 64'h1234_5678);
                set_mresp(1'b0, 1'b0, 64'h0);
            end
            if (bus.iresp.data_ok) pulses++;
        end
        check("drop_pulses", 64'(pulses), 64'h1);
        check("drop_idle", 64'(bus.mreq.valid), 64'h0);
        $display("valid-drop transaction: pulses=%0d", pulses);

        // Reset asserted mid-DBUS abandons the transaction
        bus.dreq.valid  = 1'b1;
        bus.dreq.addr   = 64'h300;
        bus.dreq.strobe = 8'hFF;
        @(negedge clk);
        check("rst_pre_mval", 64'(bus.mreq.valid), 64'h1);
        bus.dreq.valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_async_mreq", 64'(bus.mreq), 64'h0);
        check("rst_async_dok", 64'(bus.dresp.data_ok), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        set_mresp(1'b1, 1'b1, 64'h77);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_after_dok", 64'(bus.dresp.data_ok), 64'h0);
            check("rst_after_mval", 64'(bus.mreq.valid), 64'h0);
        end
        set_mresp(1'b0, 1'b0, 64'h0);
        $display("reset-abandon transaction checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, meaning: max consecutive dbus grants while ibus pends before ibus is forced.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ireq  input  ibus_req_t  instruction request from core {valid, addr}.
REQ-005 iresp  output  ibus_resp_t  {addr_ok, data_ok, data[31:0]} to core.
REQ-006 dreq  input  dbus_req_t  data request from core {valid, addr, size, strobe, data}.
REQ-007 dresp  output  dbus_resp_t  {addr_ok, data_ok, data[63:0]} to core.
REQ-008 mreq  output  mbus_req_t  single-beat memory request {valid, is_write, size, addr[63:0], strobe[7:0], data[63:0]}.
REQ-009 mresp  input  mbus_resp_t  {ready, last, data[63:0]} from memory.

Function
REQ-010 FSM states: IDLE, IBUS, DBUS, IDONE, DDONE.
REQ-011 IDLE: if dreq.valid and not forced-ibus -> DBUS; else if ireq.valid -> IBUS; else stay IDLE.
REQ-012 Forced-ibus: when starve_cnt == STARVE_MAX and ireq.valid, grant IBUS even if dreq.valid.
REQ-013 starve_cnt: +1 on each DBUS grant while ireq.valid; cleared on IBUS grant or when ireq.valid low in IDLE; saturates at STARVE_MAX.
REQ-014 On grant, the selected request is latched into an internal request register; mreq is driven only from this register.
REQ-015 mreq.valid high in IBUS/DBUS only; low in IDLE, IDONE, DDONE.
REQ-016 IBUS: is_write=0, size=MSIZE4, strobe=0, addr=latched ireq.addr.
REQ-017 DBUS: is_write=(strobe!=0); size, addr, strobe, data copied from latched dreq.
REQ-018 IBUS/DBUS stay until mresp.ready && mresp.last; then -> IDONE/DDONE, capturing mresp.data.
REQ-019 IDONE: iresp.addr_ok=iresp.data_ok=1 for exactly one cycle; iresp.data = captured[31:0] if addr[2]==0, else captured[63:32]; -> IDLE.
REQ-020 DDONE: dresp.addr_ok=dresp.data_ok=1 for exactly one cycle; dresp.data = captured 64 bits; -> IDLE.
REQ-021 No grant is made in IDONE/DDONE; minimum turnaround is one IDLE cycle between transactions.
REQ-022 Upstream valid dropped mid-transaction: downstream transaction completes; the done-cycle response is still pulsed and ignored by core.
REQ-023 Upstream request change mid-transaction has no effect on mreq (latched).
REQ-024 iresp/dresp ok flags are 0 in all states other than IDONE/DDONE respectively.
REQ-025 Simultaneous ireq.valid and dreq.valid in IDLE with starve_cnt<STARVE_MAX: dbus wins.

Reset
REQ-026 reset low asynchronously forces IDLE, starve_cnt=0, request and data registers=0.
REQ-027 During and after reset: mreq.valid=0, iresp and dresp all-zero.
REQ-028 Reset mid-transaction abandons it; no response is produced for it.

Structure
REQ-029 mbus_req_t, mbus_resp_t and msize_t (MSIZE1/2/4/8) belong in package common, beside ibus/dbus types.
REQ-030 The FSM state enum is local to the module.
REQ-031 A single module with no sub-modules; it sits between core ireq/dreq and the memory port.

Verification
REQ-032 ireq.valid, addr=0x8000_0004, mresp ready+last after 3 cycles, data=0x1111_2222_3333_4444 -> iresp.data_ok one cycle, data=0x1111_2222.
REQ-033 ireq and dreq both valid in IDLE (dreq addr=0x8000_1000, strobe=0xFF, data=0xDEAD) -> DBUS first with mreq.is_write=1; IBUS is granted after DDONE+IDLE.
REQ-034 dreq held valid continuously with ireq valid, STARVE_MAX=4 -> 5th grant goes to IBUS.
REQ-035 reset driven low while in DBUS with mresp.ready=0 -> mreq.valid=0 immediately; no dresp.data_ok after reset release.
REQ-036 dreq.addr changed from 0x100 to 0x200 mid-DBUS -> mreq.addr remains 0x100 until completion.
REQ-037 ireq.valid dropped during IBUS -> transaction completes, single iresp.data_ok pulse, FSM returns to IDLE.
